// File: rtl/keypad_scanner_if.sv
// Keypad scanner bus: row sense lines in, column drive and key report out.
// "master" is the scanner side; "slave" is the keypad/consumer side.
interface keypad_scanner_if;
  logic [3:0] key_row;
  logic [3:0] key_col;
  logic [3:0] keypadBuf;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  key_row,
    output key_col,
    output keypadBuf,
    output key_valid,
    output key_held
  );

  modport slave (
    output key_row,
    input  key_col,
    input  keypadBuf,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks one active-low column at a time, debounces
// press and release on the synchronized rows, and reports the key code.
module keypad_scanner #(
  parameter int unsigned SCAN_HOLD    = 4,
  parameter int unsigned DEBOUNCE_CNT = 8
) (
  input logic               div_clk,
  input logic               rst,
  keypad_scanner_if.master  kp_if
);

  typedef enum logic [1:0] {
    SCAN         = 2'd0,
    DEBOUNCE     = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_e;

  localparam logic [3:0] HOLD_LAST = 4'(SCAN_HOLD - 1);
  localparam logic [7:0] DEB_LAST  = 8'(DEBOUNCE_CNT - 1);

  state_e     state_q, state_d;
  logic [1:0] col_q, col_d;
  logic [3:0] hcnt_q, hcnt_d;
  logic [7:0] dcnt_q, dcnt_d;
  logic [3:0] row_pat_q, row_pat_d;
  logic [3:0] sync1_q, rs_q;
  logic [3:0] key_col_q, key_col_d;
  logic [3:0] buf_q, buf_d;
  logic       valid_q, valid_d;
  logic       held_q, held_d;

  // Lowest-numbered low row wins when several rows are pressed together.
  function automatic logic [1:0] lowest_zero(input logic [3:0] pat);
    logic [1:0] idx;
    if (!pat[0]) begin
      idx = 2'd0;
    end else if (!pat[1]) begin
      idx = 2'd1;
    end else if (!pat[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  // Two-flop synchronizer for the asynchronous row lines.
  always_ff @(posedge div_clk) begin
    if (!rst) begin
      sync1_q <= 4'hF;
      rs_q    <= 4'hF;
    end else begin
      sync1_q <= kp_if.key_row;
      rs_q    <= sync1_q;
    end
  end

  // Next-state logic for the scan / debounce / release controller.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    hcnt_d    = hcnt_q;
    dcnt_d    = dcnt_q;
    row_pat_d = row_pat_q;
    buf_d     = buf_q;
    valid_d   = 1'b0;
    case (state_q)
      SCAN: begin
        if (hcnt_q == HOLD_LAST) begin
          hcnt_d = 4'd0;
          if (rs_q == 4'hF) begin
            col_d = col_q + 2'd1;
          end else begin
            row_pat_d = rs_q;
            dcnt_d    = 8'd0;
            state_d   = DEBOUNCE;
          end
        end else begin
          hcnt_d = hcnt_q + 4'd1;
        end
      end
      DEBOUNCE: begin
        if (rs_q != row_pat_q) begin
          hcnt_d  = 4'd0;
          state_d = SCAN;
        end else if (dcnt_q == DEB_LAST) begin
          buf_d   = {lowest_zero(row_pat_q), col_q};
          valid_d = 1'b1;
          dcnt_d  = 8'd0;
          state_d = WAIT_RELEASE;
        end else begin
          dcnt_d = dcnt_q + 8'd1;
        end
      end
      WAIT_RELEASE: begin
        // Any low row during release restarts the stability count.
        if (rs_q != 4'hF) begin
          dcnt_d = 8'd0;
        end else if (dcnt_q == DEB_LAST) begin
          dcnt_d  = 8'd0;
          hcnt_d  = 4'd0;
          col_d   = col_q + 2'd1;
          state_d = SCAN;
        end else begin
          dcnt_d = dcnt_q + 8'd1;
        end
      end
      default: begin
        hcnt_d  = 4'd0;
        dcnt_d  = 8'd0;
        col_d   = 2'd0;
        state_d = SCAN;
      end
    endcase
    key_col_d = ~(4'b0001 << col_d);
    held_d    = (state_d == WAIT_RELEASE);
  end

  // Controller state and registered outputs.
  always_ff @(posedge div_clk) begin
    if (!rst) begin
      state_q   <= SCAN;
      col_q     <= 2'd0;
      hcnt_q    <= 4'd0;
      dcnt_q    <= 8'd0;
      row_pat_q <= 4'hF;
      key_col_q <= 4'b1110;
      buf_q     <= 4'h0;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      hcnt_q    <= hcnt_d;
      dcnt_q    <= dcnt_d;
      row_pat_q <= row_pat_d;
      key_col_q <= key_col_d;
      buf_q     <= buf_d;
      valid_q   <= valid_d;
      held_q    <= held_d;
    end
  end

  assign kp_if.key_col   = key_col_q;
  assign kp_if.keypadBuf = buf_q;
  assign kp_if.key_valid = valid_q;
  assign kp_if.key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a physical keypad model drives the
// rows, table vectors, hand sequences and random presses check the reports.
module tb_keypad_scanner;
  localparam int SCAN_HOLD    = 4;
  localparam int DEBOUNCE_CNT = 8;

  logic div_clk = 1'b0;
  logic rst;
  keypad_scanner_if kif();

  keypad_scanner #(.SCAN_HOLD(SCAN_HOLD), .DEBOUNCE_CNT(DEBOUNCE_CNT)) dut (
    .div_clk (div_clk),
    .rst     (rst),
    .kp_if   (kif.master)
  );

  always #5 div_clk = ~div_clk;

  int          tests = 0;
  int          fails = 0;
  int          valid_cnt = 0;
  int          col_bad = 0;
  logic [15:0] keys = 16'h0000;   // bit row*4+col set = that key is pressed
  bit          raw = 1'b0;        // when set, the sequence drives key_row itself

  typedef struct {
    logic [15:0] keys;
    int          hold;
    int          exp_pulses;
    logic [3:0]  exp_code;
  } vec_t;

  // Mid-cycle monitor: counts valid pulses and checks the column drive shape.
  always @(negedge div_clk) begin
    if (kif.key_valid === 1'b1) valid_cnt <= valid_cnt + 1;
    if (!(kif.key_col inside {4'b1110, 4'b1101, 4'b1011, 4'b0111})) col_bad <= col_bad + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] rows_of(input logic [3:0] col, input logic [15:0] k);
    logic [3:0] r;
    r = 4'hF;
    for (int ri = 0; ri < 4; ri++)
      for (int ci = 0; ci < 4; ci++)
        if (!col[ci] && k[ri*4+ci]) r[ri] = 1'b0;
    return r;
  endfunction

  task automatic tick();
    @(posedge div_clk);
    #1;
    if (!raw) kif.key_row = rows_of(kif.key_col, keys);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // Returns in the first cycle that the target column is driven.
  task automatic wait_col_start(input logic [3:0] target);
    int n;
    n = 0;
    while (kif.key_col === target && n < 100) begin tick(); n++; end
    while (kif.key_col !== target && n < 100) begin tick(); n++; end
    check("wait_col", kif.key_col, target);
  endtask

  initial begin
    vec_t       tbl[7];
    logic [3:0] exp_col;
    logic [3:0] model_code;
    int         p0;
    int         n;
    int         k;
    int         long_press;
    int         hold;

    rst = 1'b0;
    kif.key_row = 4'hF;
    tick();
    tick();
    check("rst_key_col", kif.key_col, 4'b1110);
    check("rst_buf", kif.keypadBuf, 4'h0);
    check("rst_valid", kif.key_valid, 1'b0);
    check("rst_held", kif.key_held, 1'b0);
    rst = 1'b1;

    // Idle scan: each column held 4 cycles, wrapping.
    for (int i = 1; i <= 36; i++) begin
      tick();
      exp_col = ~(4'b0001 << ((i / 4) % 4));
      check("idle_col", kif.key_col, exp_col);
    end
    check("idle_no_valid", valid_cnt, 0);
    check("idle_buf", kif.keypadBuf, 4'h0);

    // Single press row 2 / column 1: exact latency, then release timing.
    wait_col_start(4'b1110);
    keys = 16'h0200;
    p0 = valid_cnt;
    wait_col_start(4'b1101);
    for (int i = 1; i <= 40; i++) begin
      tick();
      check("press_valid_cycle", kif.key_valid, (i == 12));
    end
    check("press_buf", kif.keypadBuf, 4'h9);
    check("press_held", kif.key_held, 1'b1);
    check("press_pulses", valid_cnt - p0, 1);
    keys = 16'h0000;
    for (int j = 0; j <= 10; j++) begin
      tick();
      check("release_held", kif.key_held, (j < 10));
      if (j == 10) check("release_next_col", kif.key_col, 4'b1011);
    end
    check("release_pulses", valid_cnt - p0, 1);

    // Bounce in column 3: sample plus 3 debounce cycles, then high.
    wait_col_start(4'b0111);
    raw = 1'b1;
    p0 = valid_cnt;
    for (int i = 1; i <= 12; i++) begin
      tick();
      kif.key_row = (i <= 4) ? 4'b1110 : 4'hF;
      exp_col = (i <= 11) ? 4'b0111 : 4'b1110;
      check("bounce_col", kif.key_col, exp_col);
    end
    raw = 1'b0;
    check("bounce_no_valid", valid_cnt - p0, 0);
    check("bounce_buf", kif.keypadBuf, 4'h9);

    // Table of presses, each started at the beginning of a column-0 sweep.
    tbl[0] = '{16'h0200, 40, 1, 4'h9};
    tbl[1] = '{16'h4040, 40, 1, 4'h6};
    tbl[2] = '{16'h1000, 40, 1, 4'hC};
    tbl[3] = '{16'h0010,  6, 0, 4'hC};
    tbl[4] = '{16'h8000, 40, 1, 4'hF};
    tbl[5] = '{16'h0001, 40, 1, 4'h0};
    tbl[6] = '{16'h0808, 40, 1, 4'h3};
    for (int t = 0; t < 7; t++) begin
      wait_col_start(4'b1110);
      p0 = valid_cnt;
      keys = tbl[t].keys;
      repeat (tbl[t].hold) tick();
      keys = 16'h0000;
      repeat (30) tick();
      check("tbl_pulses", valid_cnt - p0, tbl[t].exp_pulses);
      check("tbl_buf", kif.keypadBuf, tbl[t].exp_code);
      check("tbl_held", kif.key_held, 1'b0);
    end

    // Long hold, then a release glitch that restarts the release count.
    wait_col_start(4'b1110);
    p0 = valid_cnt;
    keys = 16'h1000;
    repeat (100) tick();
    check("hold_pulses", valid_cnt - p0, 1);
    check("hold_buf", kif.keypadBuf, 4'hC);
    keys = 16'h0000;
    raw = 1'b1;
    for (int j = 0; j <= 20; j++) begin
      tick();
      kif.key_row = (j >= 5 && j <= 7) ? 4'b0111 : 4'hF;
      check("glitch_held", kif.key_held, (j <= 17));
      if (j == 18) check("glitch_next_col", kif.key_col, 4'b1101);
    end
    raw = 1'b0;
    check("glitch_pulses", valid_cnt - p0, 1);

    // Reset in the middle of a debounce: the press is dropped.
    wait_col_start(4'b1110);
    p0 = valid_cnt;
    keys = 16'h1000;
    repeat (6) tick();
    rst = 1'b0;
    keys = 16'h0000;
    tick();
    rst = 1'b1;
    check("rst_deb_held", kif.key_held, 1'b0);
    check("rst_deb_col", kif.key_col, 4'b1110);
    repeat (30) tick();
    check("rst_deb_pulses", valid_cnt - p0, 0);

    // Reset while waiting for release after code C was reported.
    wait_col_start(4'b1110);
    p0 = valid_cnt;
    keys = 16'h1000;
    n = 0;
    while (kif.key_held !== 1'b1 && n < 60) begin tick(); n++; end
    check("rst_wr_buf_before", kif.keypadBuf, 4'hC);
    check("rst_wr_held_before", kif.key_held, 1'b1);
    rst = 1'b0;
    keys = 16'h0000;
    tick();
    rst = 1'b1;
    check("rst_wr_buf", kif.keypadBuf, 4'h0);
    check("rst_wr_held", kif.key_held, 1'b0);
    check("rst_wr_col", kif.key_col, 4'b1110);
    check("rst_wr_valid", kif.key_valid, 1'b0);
    repeat (30) tick();
    check("rst_wr_pulses", valid_cnt - p0, 1);

    // Random presses: long ones report their own code once, short taps nothing.
    model_code = 4'h0;
    for (int r = 0; r < 20; r++) begin
      k = $urandom_range(0, 15);
      long_press = $urandom_range(0, 1);
      hold = long_press ? $urandom_range(45, 70) : $urandom_range(1, 8);
      p0 = valid_cnt;
      keys = 16'h0001 << k;
      repeat (hold) tick();
      keys = 16'h0000;
      repeat ($urandom_range(20, 35)) tick();
      if (long_press != 0) model_code = 4'(k);
      check("rand_pulses", valid_cnt - p0, long_press);
      check("rand_buf", kif.keypadBuf, model_code);
      check("rand_held", kif.key_held, 1'b0);
    end

    check("col_onehot", col_bad, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_HOLD, default 4: cycles each column is driven before sampling; legal range 3..15.
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 8: consecutive stable cycles needed for press and for release; legal range 2..255.
REQ-003 SHALL have port div_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port key_row, input, 4 bits: keypad row lines, active-low (pulled up), asynchronous to div_clk.
REQ-006 SHALL have port key_col, output, 4 bits: keypad column drive, active-low, exactly one bit low at all times.
REQ-007 SHALL have port keypadBuf, output, 4 bits: last debounced key code, 4'h0..4'hF, consumed by the dot-matrix controller.
REQ-008 SHALL have port key_valid, output, 1 bit: one-cycle pulse when keypadBuf is updated with a new press.
REQ-009 SHALL have port key_held, output, 1 bit: high while an accepted key has not yet been debounced as released.

Function
REQ-010 SHALL pass key_row through a two-flop synchronizer (rs); all decisions use rs only.
REQ-011 SHALL drive key_col = ~(4'b0001 << col_idx), where col_idx is 2 bits and wraps 3->0.
REQ-012 SHALL implement FSM states SCAN, DEBOUNCE, WAIT_RELEASE, with hold counter hcnt and stability counter dcnt.
REQ-013 SCAN: hcnt SHALL increment each cycle; at hcnt==SCAN_HOLD-1 (sample cycle) with rs==4'hF: hcnt<=0, col_idx<=col_idx+1.
REQ-014 SCAN: at the sample cycle with rs!=4'hF: capture row_pat<=rs, dcnt<=0, go to DEBOUNCE; col_idx SHALL stay frozen.
REQ-015 DEBOUNCE: when rs==row_pat, dcnt SHALL increment.
REQ-016 DEBOUNCE: on any cycle with rs!=row_pat, SHALL return to SCAN with hcnt<=0 and col_idx unchanged, and SHALL NOT pulse key_valid.
REQ-017 DEBOUNCE: when dcnt==DEBOUNCE_CNT-1 and rs==row_pat, SHALL load keypadBuf<=row_idx*4+col_idx, assert key_valid next cycle for exactly one cycle, set dcnt<=0, and go to WAIT_RELEASE.
REQ-018 row_idx SHALL be the index of the lowest-numbered zero bit of row_pat (lowest row wins on multiple presses).
REQ-019 Latency: with sample cycle T and stable rs, key_valid SHALL be high in cycle T+DEBOUNCE_CNT+1, with keypadBuf updated on the same edge.
REQ-020 WAIT_RELEASE: col_idx SHALL stay frozen and key_held SHALL be 1.
REQ-021 WAIT_RELEASE: dcnt SHALL increment while rs==4'hF and clear to 0 on any rs!=4'hF; no further key_valid pulses SHALL occur.
REQ-022 WAIT_RELEASE: when dcnt==DEBOUNCE_CNT-1 and rs==4'hF, SHALL go to SCAN with hcnt<=0 and col_idx<=col_idx+1.
REQ-023 keypadBuf SHALL hold its value between presses and change only per REQ-017.
REQ-024 key_held SHALL be 0 in SCAN and DEBOUNCE.

Reset
REQ-025 With rst==0 at a rising edge, SHALL set: state SCAN, col_idx 0, hcnt 0, dcnt 0, row_pat 4'hF, synchronizer flops 4'hF, key_col 4'b1110, keypadBuf 4'h0, key_valid 0, key_held 0.
REQ-026 Reset SHALL take priority in every state, including mid-DEBOUNCE and mid-WAIT_RELEASE; no key_valid SHALL be emitted for an interrupted press.

Verification (SCAN_HOLD=4, DEBOUNCE_CNT=8)
REQ-027 Idle scan: reset, then key_row=4'hF -> key_col repeats 1110,1101,1011,0111, 4 cycles each, wrapping; key_valid never 1; keypadBuf stays 0.
REQ-028 Single press: row 2 pulled low only while key_col[1]==0, held 40 cycles -> one key_valid pulse, keypadBuf=4'h9, key_held=1; key_held drops 8+2 cycles after release; scan resumes at column 2.
REQ-029 Bounce: row 0 low in column 3 for the sample plus 3 DEBOUNCE cycles, then high -> no key_valid, keypadBuf unchanged, key_col stays 0111 for 4 more cycles, then 1110.
REQ-030 Multi-row: rows 1 and 3 both low in column 2, stable -> keypadBuf=4'h6 (lowest row wins).
REQ-031 Release glitch and held key: key held 100 cycles -> exactly one pulse; on release, a 3-cycle low glitch at release-dcnt 5 restarts the count; SCAN resumes only after 8 clean high cycles.
REQ-032 Mid-operation reset: assert rst=0 for one cycle during WAIT_RELEASE after keypadBuf=4'hC -> next cycle keypadBuf=0, key_held=0, key_col=1110, key_valid=0.
